// File: rtl/jk_fsm_bank.sv
// jk_fsm_bank: bank of NUM_CH independent JK on/off Moore channels
// with conflict mode, minimum dwell and registered edge pulses.
// Optional transition counters: define JK_FSM_BANK_TRANSITION_COUNT_EN.
module jk_fsm_bank #(
    parameter int NUM_CH  = 4,
    parameter int DWELL_W = 4,
    parameter int MODE    = 0,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       j,
    input  logic [NUM_CH-1:0]       k,
    input  logic [DWELL_W-1:0]      min_dwell,
`ifdef JK_FSM_BANK_TRANSITION_COUNT_EN
    input  logic                    cnt_clr,
    output logic [NUM_CH*CNT_W-1:0] trans_cnt,
`endif
    output logic [NUM_CH-1:0]       out,
    output logic [NUM_CH-1:0]       rise,
    output logic [NUM_CH-1:0]       fall
);

    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    logic [NUM_CH-1:0]  state;
    logic [NUM_CH-1:0]  req;
    logic [NUM_CH-1:0]  ok;
    logic [NUM_CH-1:0]  chg;
    logic [DWELL_W-1:0] dwell_cnt [NUM_CH];

    assign out = state;

    // Requested next state per channel and whether it may be taken now
    always_comb begin
        req = '0;
        ok  = '0;
        chg = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (j[i] && k[i]) begin
                if (MODE == 1) begin
                    req[i] = 1'b1;
                end else if (MODE == 2) begin
                    req[i] = 1'b0;
                end else begin
                    req[i] = ~state[i];
                end
            end else if (j[i]) begin
                req[i] = 1'b1;
            end else if (k[i]) begin
                req[i] = 1'b0;
            end else begin
                req[i] = state[i];
            end
            ok[i]  = en && (dwell_cnt[i] >= min_dwell);
            chg[i] = ok[i] && (req[i] != state[i]);
        end
    end

    // Channel state and edge pulses, updated together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= '0;
            rise  <= '0;
            fall  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (chg[i]) begin
                    state[i] <= req[i];
                    rise[i]  <= req[i];
                    fall[i]  <= ~req[i];
                end else begin
                    rise[i]  <= 1'b0;
                    fall[i]  <= 1'b0;
                end
            end
        end
    end

    // Dwell counters: cleared on change, otherwise saturate upward even when en=0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                dwell_cnt[i] <= DWELL_MAX;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (chg[i]) begin
                    dwell_cnt[i] <= '0;
                end else if (dwell_cnt[i] != DWELL_MAX) begin
                    dwell_cnt[i] <= dwell_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef JK_FSM_BANK_TRANSITION_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating per-channel transition counters; clear wins over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trans_cnt <= '0;
        end else if (cnt_clr) begin
            trans_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (chg[i] && (trans_cnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                    trans_cnt[i*CNT_W +: CNT_W] <=
                        trans_cnt[i*CNT_W +: CNT_W] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_jk_fsm_bank.sv
// tb_jk_fsm_bank: table vectors, corner sequences and random stimulus
// against a behavioural model, for MODE 0/1/2 instances in parallel.
module tb_jk_fsm_bank;

    localparam int N    = 4;
    localparam int DW   = 4;
    localparam int CW   = 2;
    localparam int DMAX = (1 << DW) - 1;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          en    = 1'b0;
    logic [N-1:0]  j     = '0;
    logic [N-1:0]  k     = '0;
    logic [DW-1:0] md    = '0;

    logic [N-1:0] o_out  [3];
    logic [N-1:0] o_rise [3];
    logic [N-1:0] o_fall [3];

`ifdef JK_FSM_BANK_TRANSITION_COUNT_EN
    logic          cnt_clr = 1'b0;
    logic [N*CW-1:0] o_cnt [3];
    int            m_cnt [3][N];
`endif

    int errors = 0;
    int checks = 0;

    // behavioural model: level, cycles since last change, last pulses
    bit m_out  [3][N];
    int m_age  [3][N];
    bit m_rise [3][N];
    bit m_fall [3][N];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        jk_fsm_bank #(
            .NUM_CH(N), .DWELL_W(DW), .MODE(m), .CNT_W(CW)
        ) dut (
            .clk(clk),
            .reset(reset),
            .en(en),
            .j(j),
            .k(k),
            .min_dwell(md),
`ifdef JK_FSM_BANK_TRANSITION_COUNT_EN
            .cnt_clr(cnt_clr),
            .trans_cnt(o_cnt[m]),
`endif
            .out(o_out[m]),
            .rise(o_rise[m]),
            .fall(o_fall[m])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int m = 0; m < 3; m++) begin
            for (int c = 0; c < N; c++) begin
                m_out[m][c]  = 1'b0;
                m_age[m][c]  = DMAX;
                m_rise[m][c] = 1'b0;
                m_fall[m][c] = 1'b0;
`ifdef JK_FSM_BANK_TRANSITION_COUNT_EN
                m_cnt[m][c]  = 0;
`endif
            end
        end
    endtask

    // one clock edge of the model using the inputs currently applied
    task automatic mstep();
        bit want;
        for (int m = 0; m < 3; m++) begin
            for (int c = 0; c < N; c++) begin
                if (j[c] && k[c])
                    want = (m == 1) ? 1'b1 : (m == 2) ? 1'b0 : !m_out[m][c];
                else if (j[c])
                    want = 1'b1;
                else if (k[c])
                    want = 1'b0;
                else
                    want = m_out[m][c];
                if (en && m_age[m][c] >= int'(md) && want != m_out[m][c]) begin
                    m_out[m][c]  = want;
                    m_rise[m][c] = want;
                    m_fall[m][c] = !want;
                    m_age[m][c]  = 0;
`ifdef JK_FSM_BANK_TRANSITION_COUNT_EN
                    if (!cnt_clr && m_cnt[m][c] < CMAX) m_cnt[m][c]++;
`endif
                end else begin
                    m_rise[m][c] = 1'b0;
                    m_fall[m][c] = 1'b0;
                    if (m_age[m][c] < DMAX) m_age[m][c]++;
                end
`ifdef JK_FSM_BANK_TRANSITION_COUNT_EN
                if (cnt_clr) m_cnt[m][c] = 0;
`endif
            end
        end
    endtask

    task automatic cmp_all();
        logic [N-1:0] eo, er, ef;
        for (int m = 0; m < 3; m++) begin
            for (int c = 0; c < N; c++) begin
                eo[c] = m_out[m][c];
                er[c] = m_rise[m][c];
                ef[c] = m_fall[m][c];
            end
            chk($sformatf("model m%0d out", m), 32'(o_out[m]), 32'(eo));
            chk($sformatf("model m%0d rise", m), 32'(o_rise[m]), 32'(er));
            chk($sformatf("model m%0d fall", m), 32'(o_fall[m]), 32'(ef));
`ifdef JK_FSM_BANK_TRANSITION_COUNT_EN
            for (int c = 0; c < N; c++)
                chk($sformatf("model m%0d cnt%0d", m, c),
                    32'(o_cnt[m][c*CW +: CW]), 32'(m_cnt[m][c]));
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        mstep();
        #1;
        cmp_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mreset();
        #1;
        chk("reset out", 32'(o_out[0]), 32'h0);
        chk("reset rise", 32'(o_rise[0]), 32'h0);
        chk("reset fall", 32'(o_fall[0]), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        j = '0;
        k = '0;
    endtask

    typedef struct {
        logic [N-1:0]  j;
        logic [N-1:0]  k;
        logic          en;
        logic [DW-1:0] md;
        logic [N-1:0]  eo;
        logic [N-1:0]  er;
        logic [N-1:0]  ef;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{4'b0101, 4'b0000, 1'b1, 4'd0, 4'b0101, 4'b0101, 4'b0000};
        tbl[1] = '{4'b0000, 4'b0000, 1'b1, 4'd0, 4'b0101, 4'b0000, 4'b0000};
        tbl[2] = '{4'b0001, 4'b0001, 1'b1, 4'd0, 4'b0100, 4'b0000, 4'b0001};
        tbl[3] = '{4'b0001, 4'b0001, 1'b1, 4'd0, 4'b0101, 4'b0001, 4'b0000};
        tbl[4] = '{4'b0001, 4'b0001, 1'b1, 4'd0, 4'b0100, 4'b0000, 4'b0001};
        tbl[5] = '{4'b0001, 4'b0001, 1'b1, 4'd0, 4'b0101, 4'b0001, 4'b0000};
        tbl[6] = '{4'b0001, 4'b0001, 1'b1, 4'd0, 4'b0100, 4'b0000, 4'b0001};
        tbl[7] = '{4'b0001, 4'b0001, 1'b1, 4'd0, 4'b0101, 4'b0001, 4'b0000};
        tbl[8] = '{4'b0001, 4'b0001, 1'b1, 4'd0, 4'b0100, 4'b0000, 4'b0001};
        tbl[9] = '{4'b0000, 4'b0100, 1'b1, 4'd0, 4'b0000, 4'b0000, 4'b0100};

        #2;
        do_reset();
        en = 1'b1;
        md = '0;

        // basic set, conflict toggling, clear
        for (int i = 0; i < 10; i++) begin
            j  = tbl[i].j;
            k  = tbl[i].k;
            en = tbl[i].en;
            md = tbl[i].md;
            step();
            chk($sformatf("tbl%0d out", i), 32'(o_out[0]), 32'(tbl[i].eo));
            chk($sformatf("tbl%0d rise", i), 32'(o_rise[0]), 32'(tbl[i].er));
            chk($sformatf("tbl%0d fall", i), 32'(o_fall[0]), 32'(tbl[i].ef));
        end

        // MODE 1 / MODE 2 conflict from off
        do_reset();
        en = 1'b1;
        md = '0;
        j  = 4'b0001;
        k  = 4'b0001;
        step();
        chk("m1 out on", 32'(o_out[1]), 32'h1);
        chk("m1 rise", 32'(o_rise[1]), 32'h1);
        chk("m2 out off", 32'(o_out[2]), 32'h0);
        chk("m2 rise", 32'(o_rise[2]), 32'h0);
        step();
        chk("m1 stays on", 32'(o_out[1]), 32'h1);
        chk("m1 no rise", 32'(o_rise[1]), 32'h0);
        chk("m2 stays off", 32'(o_out[2]), 32'h0);
        chk("m2 no fall", 32'(o_fall[2]), 32'h0);

        // minimum dwell and live min_dwell change
        do_reset();
        en = 1'b1;
        md = 4'd3;
        j  = 4'b0001;
        k  = 4'b0000;
        step();
        chk("dwell rise", 32'(o_rise[0]), 32'h1);
        j = 4'b0000;
        k = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("dwell hold%0d", i), 32'(o_out[0]), 32'h1);
        end
        step();
        chk("dwell fall out", 32'(o_out[0]), 32'h0);
        chk("dwell fall", 32'(o_fall[0]), 32'h1);
        j = 4'b0001;
        k = 4'b0000;
        step();
        chk("dwell block", 32'(o_out[0]), 32'h0);
        md = 4'd0;
        step();
        chk("dwell md0 out", 32'(o_out[0]), 32'h1);
        chk("dwell md0 rise", 32'(o_rise[0]), 32'h1);

        // en freeze, then async reset mid-pulse
        do_reset();
        en = 1'b0;
        j  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("en0 out%0d", i), 32'(o_out[0]), 32'h0);
            chk($sformatf("en0 rise%0d", i), 32'(o_rise[0]), 32'h0);
        end
        en = 1'b1;
        step();
        chk("en1 out", 32'(o_out[0]), 32'hf);
        chk("en1 rise", 32'(o_rise[0]), 32'hf);
        #2;
        reset = 1'b0;
        #1;
        chk("async out", 32'(o_out[0]), 32'h0);
        chk("async rise", 32'(o_rise[0]), 32'h0);
        mreset();
        cmp_all();
        @(negedge clk);
        reset = 1'b1;

`ifdef JK_FSM_BANK_TRANSITION_COUNT_EN
        // counter saturation and clear priority
        do_reset();
        en = 1'b1;
        md = '0;
        j  = 4'b0010;
        k  = 4'b0010;
        for (int i = 0; i < 5; i++) step();
        chk("cnt sat", 32'(o_cnt[0][3:2]), 32'd3);
        cnt_clr = 1'b1;
        step();
        chk("cnt clr", 32'(o_cnt[0][3:2]), 32'd0);
        cnt_clr = 1'b0;
`endif

        // random stimulus against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            j  = N'($urandom);
            k  = N'($urandom);
            en = ($urandom % 8) != 0;
            md = ($urandom % 4 == 0) ? DW'($urandom % 16) : DW'($urandom % 3);
`ifdef JK_FSM_BANK_TRANSITION_COUNT_EN
            cnt_clr = ($urandom % 16) == 0;
`endif
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
